// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) answering the EX-stage start/ready handshake.
// One quotient bit per cycle; signed operands are divided as magnitudes and the signs are fixed up at the end.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_DBZ, S_ON, S_END} state_t;

    state_t               state, state_n;
    logic [DATA_W-1:0]    dvd, dvd_n;       // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]    dvs, dvs_n;
    logic [DATA_W-1:0]    rem, rem_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 sign_q, sign_q_n;
    logic                 sign_r, sign_r_n;
    logic [2*DATA_W-1:0]  result_n;
    logic                 ready_n;

    logic [DATA_W-1:0]    abs1, abs2;
    logic [DATA_W:0]      rem_sh, diff;
    logic                 qbit;
    logic [DATA_W-1:0]    rem_step, dvd_step;
    logic [DATA_W-1:0]    quot_fin, rem_fin;

    // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits, so the overflow case needs no special path
    assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    assign rem_sh   = {rem, dvd[DATA_W-1]};
    assign diff     = rem_sh - {1'b0, dvs};
    assign qbit     = ~diff[DATA_W];
    assign rem_step = qbit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign dvd_step = {dvd[DATA_W-2:0], qbit};
    assign quot_fin = sign_q ? -dvd_step : dvd_step;
    assign rem_fin  = sign_r ? -rem_step : rem_step;

    always_comb begin
        state_n  = state;
        dvd_n    = dvd;
        dvs_n    = dvs;
        rem_n    = rem;
        cnt_n    = cnt;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        result_n = result_o;
        ready_n  = ready_o;
        case (state)
            S_IDLE: begin
                result_n = '0;
                ready_n  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = S_DBZ;
                    end else begin
                        dvd_n    = abs1;
                        dvs_n    = abs2;
                        rem_n    = '0;
                        cnt_n    = '0;
                        sign_q_n = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        sign_r_n = signed_div_i & opdata1_i[DATA_W-1];
                        state_n  = S_ON;
                    end
                end
            end
            S_DBZ: begin
                if (annul_i) begin
                    state_n = S_IDLE;
                end else begin
                    result_n = '0;
                    ready_n  = 1'b1;
                    state_n  = S_END;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    ready_n = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    dvd_n = dvd_step;
                    rem_n = rem_step;
                    if (cnt == LAST) begin
                        result_n = {rem_fin, quot_fin};
                        ready_n  = 1'b1;
                        state_n  = S_END;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_END: begin
                if (!start_i || annul_i) begin
                    result_n = '0;
                    ready_n  = 1'b0;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            dvd      <= dvd_n;
            dvs      <= dvs_n;
            rem      <= rem_n;
            cnt      <= cnt_n;
            sign_q   <= sign_q_n;
            sign_r   <= sign_r_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed vector table, annul/reset sequences, and random divides
// checked against plain-arithmetic division.
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_iter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: language division (truncates toward zero, remainder takes dividend sign)
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Holds start until ready, scrambling operands mid-flight; checks latency, result,
    // hold-while-start behaviour and return to idle.
    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int edges;
        int exp_lat;
        logic [63:0] held;
        exp_lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                signed_div_i = ~sgn;
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
            end
        end while (!ready_o && edges < 100);
        check({name, " ready"}, 64'(ready_o), 64'd1);
        check({name, " latency"}, 64'(edges), 64'(exp_lat));
        check({name, " result"}, result_o, exp);
        held = result_o;
        @(posedge clk); #1;
        check({name, " hold"}, {result_o[62:0], ready_o}, {held[62:0], 1'b1});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({name, " drop"}, {63'(result_o), ready_o}, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] ra, rb;
        bit          rs;
        int          seen;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {result_o[62:0], ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{1'b0, 32'd7,          32'd2,          64'h00000001_00000003});
        vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD});
        vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000});
        vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF});
        vecs.push_back('{1'b0, 32'd1234,       32'd0,          64'd0});
        vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003});
        vecs.push_back('{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC});
        vecs.push_back('{1'b0, 32'd3,          32'hFFFFFFFF,   64'h00000003_00000000});
        foreach (vecs[i]) run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

        // annul mid-divide: no result may appear even though ON would otherwise finish
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd5000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        check("annul no ready", 64'(seen), 64'd0);
        run_div("after annul 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

        // synchronous reset mid-divide
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd123; opdata2_i = 32'd4; start_i = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        check("rst outputs", {result_o[62:0], ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        check("rst no ready", 64'(seen), 64'd0);
        run_div("after rst 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // annul during DBZ must also suppress the result
        @(negedge clk);
        opdata1_i = 32'd8; opdata2_i = 32'd0; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        check("dbz annul no ready", 64'(seen), 64'd0);

        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 15);
                3:       rb = rs ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_div($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
